// File: rtl/rf_pkg.sv
// Shared register-file constants and the register address type.
package rf_pkg;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 2;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  typedef logic [AW-1:0] reg_addr_t;
endpackage

// File: rtl/sb_counter.sv
// Saturating up/down in-flight write counter for one register.
// ovf/unf flag an inc at max or a dec at zero that was refused.
module sb_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          ovf,
  output logic          unf
);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    unf   = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q == CNT_MAX) ovf = 1'b1;
      else                  cnt_d = cnt_q + CW'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) unf = 1'b1;
      else             cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/rf_scoreboard.sv
// Write-side scoreboard: tracks outstanding register writes between ID issue and WB,
// and stalls ID while a used source register still has a pending write.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = rf_pkg::NREG,
  parameter int AW   = rf_pkg::AW,
  parameter int CW   = rf_pkg::CW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic            flush,
  output logic            stall,
  output logic [NREG-1:0] busy_vec,
  output logic            sb_err
);
  logic [CW-1:0]   cnt [NREG];
  logic [NREG-1:0] inc_w, dec_w, ovf_w, unf_w;
  logic            issue_go;
  logic            dec_rs, dec_rt;
  logic [CW-1:0]   pend_rs, pend_rt;
  logic            sb_err_q;

  assign issue_go = issue_valid & issue_we & ~stall;

  assign cnt[0]   = '0;
  assign inc_w[0] = 1'b0;
  assign dec_w[0] = 1'b0;
  assign ovf_w[0] = 1'b0;
  assign unf_w[0] = 1'b0;

  // Register 0 is hard-wired zero, so only r = 1..NREG-1 get a counter.
  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    assign inc_w[r] = issue_go & (issue_rd == AW'(r));
    assign dec_w[r] = wb_valid & (wb_rd == AW'(r));

    sb_counter #(.CW(CW)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (inc_w[r]),
      .dec (dec_w[r]),
      .cnt (cnt[r]),
      .ovf (ovf_w[r]),
      .unf (unf_w[r])
    );
  end

  for (genvar r = 0; r < NREG; r++) begin : g_busy
    assign busy_vec[r] = |cnt[r];
  end

  // WB writes rf on the falling edge, so a write retiring this cycle no longer blocks ID.
  assign dec_rs  = wb_valid & (wb_rd == id_rs);
  assign dec_rt  = wb_valid & (wb_rd == id_rt);
  assign pend_rs = cnt[id_rs] - CW'(dec_rs);
  assign pend_rt = cnt[id_rt] - CW'(dec_rt);

  assign stall = rst &
                 ((id_rs_used & (id_rs != REG_ZERO) & (pend_rs != '0)) |
                  (id_rt_used & (id_rt != REG_ZERO) & (pend_rt != '0)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 sb_err_q <= 1'b0;
    else if (|{ovf_w, unf_w}) sb_err_q <= 1'b1;
  end

  assign sb_err = sb_err_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard.
module tb_rf_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_we;
  logic [4:0]  issue_rd, id_rs, id_rt, wb_rd;
  logic        id_rs_used, id_rt_used, wb_valid, flush;
  logic        stall, sb_err;
  logic [31:0] busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  rf_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_rd    (issue_rd),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .stall       (stall),
    .busy_vec    (busy_vec),
    .sb_err      (sb_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    issue_valid = 0; issue_we = 0; issue_rd = 0;
    id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_we = 1; issue_rd = rd;
  endtask

  task automatic test_reset();
    rst = 0;
    idle();
    #12;
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy got %h exp %h", busy_vec, 32'h0); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", sb_err); end
    rst = 1;
    tick();
  endtask

  task automatic test_raw();
    idle();
    issue(5'd3);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_c0_stall got %b exp 0", stall); end
    tick();
    idle();
    id_rs = 5'd3; id_rs_used = 1;
    issue(5'd6);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_c1_stall got %b exp 1", stall); end
    n_checks++; if (busy_vec[3] !== 1'b1) begin n_fail++; $display("FAIL raw_c1_busy3 got %b exp 1", busy_vec[3]); end
    tick();
    issue_valid = 0; issue_we = 0;
    #1;
    n_checks++; if (busy_vec[6] !== 1'b0) begin n_fail++; $display("FAIL raw_stalled_issue_busy6 got %b exp 0", busy_vec[6]); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_c2_stall got %b exp 1", stall); end
    tick();
    wb_valid = 1; wb_rd = 5'd3;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_c3_wb_stall got %b exp 0", stall); end
    tick();
    wb_valid = 0;
    #1;
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL raw_after_wb_busy got %h exp %h", busy_vec, 32'h0); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_after_wb_stall got %b exp 0", stall); end
  endtask

  task automatic test_r0();
    idle();
    issue(5'd0);
    id_rs = 5'd0; id_rs_used = 1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall_pre got %b exp 0", stall); end
    tick();
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL r0_busy got %h exp %h", busy_vec, 32'h0); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall_post got %b exp 0", stall); end
    idle();
  endtask

  task automatic test_double_write();
    idle();
    issue(5'd7);
    tick();
    tick();
    idle();
    id_rt = 5'd7; id_rt_used = 1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL dbl_cnt2_stall got %b exp 1", stall); end
    wb_valid = 1; wb_rd = 5'd7;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL dbl_first_wb_stall got %b exp 1", stall); end
    tick();
    wb_valid = 0;
    #1;
    n_checks++; if (busy_vec[7] !== 1'b1) begin n_fail++; $display("FAIL dbl_cnt1_busy7 got %b exp 1", busy_vec[7]); end
    id_rt_used = 0;
    issue(5'd7);
    wb_valid = 1; wb_rd = 5'd7;
    tick();
    idle();
    id_rt = 5'd7; id_rt_used = 1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL dbl_hold_stall got %b exp 1", stall); end
    n_checks++; if (busy_vec !== 32'h0000_0080) begin n_fail++; $display("FAIL dbl_hold_busy got %h exp %h", busy_vec, 32'h0000_0080); end
    wb_valid = 1; wb_rd = 5'd7;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL dbl_second_wb_stall got %b exp 0", stall); end
    tick();
    idle();
    #1;
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL dbl_final_busy got %h exp %h", busy_vec, 32'h0); end
    n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL dbl_err got %b exp 0", sb_err); end
  endtask

  task automatic test_saturation();
    idle();
    issue(5'd9);
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL sat_err_at3 got %b exp 0", sb_err); end
    n_checks++; if (busy_vec !== 32'h0000_0200) begin n_fail++; $display("FAIL sat_busy_at3 got %h exp %h", busy_vec, 32'h0000_0200); end
    tick();
    n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_err got %b exp 1", sb_err); end
    n_checks++; if (busy_vec[9] !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_busy9 got %b exp 1", busy_vec[9]); end
    idle();
    wb_valid = 1; wb_rd = 5'd9;
    tick();
    tick();
    n_checks++; if (busy_vec[9] !== 1'b1) begin n_fail++; $display("FAIL sat_after2wb_busy9 got %b exp 1", busy_vec[9]); end
    tick();
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL sat_after3wb_busy got %h exp %h", busy_vec, 32'h0); end
    wb_rd = 5'd10;
    tick();
    idle();
    #1;
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL unf_busy got %h exp %h", busy_vec, 32'h0); end
    n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL unf_err got %b exp 1", sb_err); end
  endtask

  task automatic test_flush();
    idle();
    issue(5'd4);
    tick();
    n_checks++; if (busy_vec[4] !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy4 got %b exp 1", busy_vec[4]); end
    flush = 1;
    tick();
    idle();
    id_rs = 5'd4; id_rs_used = 1;
    #1;
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL flush_busy got %h exp %h", busy_vec, 32'h0); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", stall); end
    n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL flush_err_hold got %b exp 1", sb_err); end
    idle();
  endtask

  task automatic test_reset_midrun();
    idle();
    issue(5'd5);
    tick();
    tick();
    idle();
    id_rs = 5'd5; id_rs_used = 1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre_stall got %b exp 1", stall); end
    n_checks++; if (busy_vec !== 32'h0000_0020) begin n_fail++; $display("FAIL mid_pre_busy got %h exp %h", busy_vec, 32'h0000_0020); end
    #1;
    rst = 0;
    #1;
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL mid_rst_busy got %h exp %h", busy_vec, 32'h0); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall got %b exp 0", stall); end
    n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got %b exp 0", sb_err); end
    #2;
    rst = 1;
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_post_stall got %b exp 0", stall); end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_r0();
    test_double_write();
    test_saturation();
    test_flush();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
